ceyloniac_multicycle_control: RTL and testbench

CEYLONIAC_MULTICYCLE_CONTROL -- requirements
Module: ceyloniac_multicycle_control

---
 rtl/ceyloniac_pkg.sv | 93 +++++++++
 rtl/ceyloniac_ctrl_decode.sv | 87 ++++++++
 rtl/ceyloniac_multicycle_control.sv | 114 +++++++++++
 tb/tb_ceyloniac_multicycle_control.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ceyloniac_pkg.sv
// Shared encodings for the multicycle controller: FSM states, opcodes,
// datapath select codes and the opcode classifier used by decode and next-state.
package ceyloniac_pkg;

    typedef enum logic [3:0] {
        ST_RESET     = 4'd0,
        ST_FETCH     = 4'd1,
        ST_DECODE    = 4'd2,
        ST_MEM_ADDR  = 4'd3,
        ST_MEM_READ  = 4'd4,
        ST_MEM_WB    = 4'd5,
        ST_MEM_WRITE = 4'd6,
        ST_EXECUTE   = 4'd7,
        ST_ALU_WB    = 4'd8,
        ST_BRANCH    = 4'd9,
        ST_JUMP      = 4'd10,
        ST_IMM_EXEC  = 4'd11,
        ST_IMM_WB    = 4'd12
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;
    localparam logic [1:0] ALU_OP_LOGIC = 2'b11;

    localparam logic [1:0] SRC_B_REG    = 2'b00;
    localparam logic [1:0] SRC_B_FOUR   = 2'b01;
    localparam logic [1:0] SRC_B_IMM    = 2'b10;
    localparam logic [1:0] SRC_B_BR_OFF = 2'b11;

    localparam logic [1:0] PC_SRC_ALU     = 2'b00;
    localparam logic [1:0] PC_SRC_ALU_OUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP    = 2'b10;

    typedef enum logic [2:0] {
        OPC_ILLEGAL   = 3'd0,
        OPC_RTYPE     = 3'd1,
        OPC_LOAD      = 3'd2,
        OPC_STORE     = 3'd3,
        OPC_BRANCH    = 3'd4,
        OPC_JUMP      = 3'd5,
        OPC_IMM_ADD   = 3'd6,
        OPC_IMM_LOGIC = 3'd7
    } op_class_e;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic       ext_sel;
        logic       illegal_op;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_t;

    // Opcodes are widened to this width before classification so any
    // OPCODE_WIDTH up to 32 compares against the 6-bit constants exactly.
    localparam int OP_CMP_W = 32;

    function automatic op_class_e classify_op(input logic [OP_CMP_W-1:0] op);
        op_class_e cls;
        case (op)
            OP_CMP_W'(OP_RTYPE): cls = OPC_RTYPE;
            OP_CMP_W'(OP_J):     cls = OPC_JUMP;
            OP_CMP_W'(OP_BEQ):   cls = OPC_BRANCH;
            OP_CMP_W'(OP_ADDI):  cls = OPC_IMM_ADD;
            OP_CMP_W'(OP_ANDI):  cls = OPC_IMM_LOGIC;
            OP_CMP_W'(OP_ORI):   cls = OPC_IMM_LOGIC;
            OP_CMP_W'(OP_LW):    cls = OPC_LOAD;
            OP_CMP_W'(OP_SW):    cls = OPC_STORE;
            default:             cls = OPC_ILLEGAL;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/ceyloniac_ctrl_decode.sv
// Combinational Moore output decode: current state plus latched opcode (and
// mem_ready / live opcode in FETCH / DECODE) to datapath control strobes.
module ceyloniac_ctrl_decode
    import ceyloniac_pkg::*;
#(
    parameter int OPCODE_WIDTH = 6
) (
    input  state_e                  state,
    input  logic [OPCODE_WIDTH-1:0] op_q,
    input  logic [OPCODE_WIDTH-1:0] opcode,
    input  logic                    mem_ready,
    output ctrl_t                   ctrl
);

    op_class_e cur_cls;
    op_class_e latched_cls;
    logic      imm_logic;

    always_comb begin
        cur_cls     = classify_op(OP_CMP_W'(opcode));
        latched_cls = classify_op(OP_CMP_W'(op_q));
        imm_logic   = (latched_cls == OPC_IMM_LOGIC);
        ctrl        = '0;

        case (state)
            ST_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRC_B_FOUR;
                ctrl.alu_op    = ALU_OP_ADD;
                ctrl.pc_source = PC_SRC_ALU;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            ST_DECODE: begin
                ctrl.alu_src_b  = SRC_B_BR_OFF;
                ctrl.illegal_op = (cur_cls == OPC_ILLEGAL);
            end
            ST_MEM_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRC_B_IMM;
                ctrl.alu_op    = ALU_OP_ADD;
            end
            ST_MEM_READ: begin
                ctrl.i_or_d   = 1'b1;
                ctrl.mem_read = 1'b1;
            end
            ST_MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            ST_MEM_WRITE: begin
                ctrl.i_or_d    = 1'b1;
                ctrl.mem_write = 1'b1;
            end
            ST_EXECUTE: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRC_B_REG;
                ctrl.alu_op    = ALU_OP_FUNCT;
            end
            ST_ALU_WB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            ST_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRC_B_REG;
                ctrl.alu_op        = ALU_OP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PC_SRC_ALU_OUT;
            end
            ST_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PC_SRC_JUMP;
            end
            // IMM_WB keeps the ALU controls of IMM_EXEC so the result stays stable.
            ST_IMM_EXEC, ST_IMM_WB: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRC_B_IMM;
                ctrl.alu_op    = imm_logic ? ALU_OP_LOGIC : ALU_OP_ADD;
                ctrl.ext_sel   = imm_logic;
                ctrl.reg_write = (state == ST_IMM_WB);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/ceyloniac_multicycle_control.sv
// Multicycle MIPS-style control unit: Moore FSM state register, next-state
// logic and opcode latch; output strobes come from ceyloniac_ctrl_decode.
module ceyloniac_multicycle_control
    import ceyloniac_pkg::*;
#(
    parameter int OPCODE_WIDTH = 6,
    parameter int STATE_WIDTH  = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [OPCODE_WIDTH-1:0] opcode,
    input  logic                    mem_ready,
    output logic                    pc_write,
    output logic                    pc_write_cond,
    output logic                    i_or_d,
    output logic                    mem_read,
    output logic                    mem_write,
    output logic                    ir_write,
    output logic                    mem_to_reg,
    output logic                    reg_dst,
    output logic                    reg_write,
    output logic                    alu_src_a,
    output logic                    ext_sel,
    output logic                    illegal_op,
    output logic [1:0]              alu_src_b,
    output logic [1:0]              alu_op,
    output logic [1:0]              pc_source,
    output logic [STATE_WIDTH-1:0]  state
);

    state_e                  state_q;
    state_e                  state_d;
    logic [OPCODE_WIDTH-1:0] op_q;
    logic                    rst_seen_q;
    logic [3:0]              state_bits;
    op_class_e               dec_cls;
    op_class_e               latched_cls;
    ctrl_t                   ctrl;

    // rst_seen_q holds RESET for one extra edge after release, so FETCH is
    // entered on the second rising edge once rst_n is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_RESET;
            op_q       <= '0;
            rst_seen_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rst_seen_q <= 1'b1;
            if (state_q == ST_DECODE) begin
                op_q <= opcode;
            end
        end
    end

    always_comb begin
        dec_cls     = classify_op(OP_CMP_W'(opcode));
        latched_cls = classify_op(OP_CMP_W'(op_q));
        state_d     = state_q;

        case (state_q)
            ST_RESET:     state_d = rst_seen_q ? ST_FETCH : ST_RESET;
            ST_FETCH:     state_d = mem_ready ? ST_DECODE : ST_FETCH;
            ST_DECODE: begin
                case (dec_cls)
                    OPC_LOAD, OPC_STORE:        state_d = ST_MEM_ADDR;
                    OPC_RTYPE:                  state_d = ST_EXECUTE;
                    OPC_BRANCH:                 state_d = ST_BRANCH;
                    OPC_JUMP:                   state_d = ST_JUMP;
                    OPC_IMM_ADD, OPC_IMM_LOGIC: state_d = ST_IMM_EXEC;
                    default:                    state_d = ST_FETCH;
                endcase
            end
            ST_MEM_ADDR:  state_d = (latched_cls == OPC_LOAD) ? ST_MEM_READ : ST_MEM_WRITE;
            ST_MEM_READ:  state_d = mem_ready ? ST_MEM_WB : ST_MEM_READ;
            ST_MEM_WRITE: state_d = mem_ready ? ST_FETCH : ST_MEM_WRITE;
            ST_EXECUTE:   state_d = ST_ALU_WB;
            ST_IMM_EXEC:  state_d = ST_IMM_WB;
            ST_MEM_WB, ST_ALU_WB, ST_BRANCH, ST_JUMP, ST_IMM_WB:
                          state_d = ST_FETCH;
            default:      state_d = ST_FETCH;
        endcase
    end

    ceyloniac_ctrl_decode #(
        .OPCODE_WIDTH (OPCODE_WIDTH)
    ) u_decode (
        .state     (state_q),
        .op_q      (op_q),
        .opcode    (opcode),
        .mem_ready (mem_ready),
        .ctrl      (ctrl)
    );

    assign pc_write      = ctrl.pc_write;
    assign pc_write_cond = ctrl.pc_write_cond;
    assign i_or_d        = ctrl.i_or_d;
    assign mem_read      = ctrl.mem_read;
    assign mem_write     = ctrl.mem_write;
    assign ir_write      = ctrl.ir_write;
    assign mem_to_reg    = ctrl.mem_to_reg;
    assign reg_dst       = ctrl.reg_dst;
    assign reg_write     = ctrl.reg_write;
    assign alu_src_a     = ctrl.alu_src_a;
    assign ext_sel       = ctrl.ext_sel;
    assign illegal_op    = ctrl.illegal_op;
    assign alu_src_b     = ctrl.alu_src_b;
    assign alu_op        = ctrl.alu_op;
    assign pc_source     = ctrl.pc_source;

    assign state_bits = state_q;
    assign state      = STATE_WIDTH'(state_bits);

endmodule

// File: tb/tb_ceyloniac_multicycle_control.sv
// Bench for ceyloniac_multicycle_control: instruction-sequence reference model
// checked every cycle, directed literal scenarios, then randomized traffic.
module tb_ceyloniac_multicycle_control;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] opcode = 6'h00;
    logic       mem_ready = 1'b0;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a, ext_sel, illegal_op;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic [3:0] state;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ceyloniac_multicycle_control #(
        .OPCODE_WIDTH (6),
        .STATE_WIDTH  (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .opcode        (opcode),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .i_or_d        (i_or_d),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .mem_to_reg    (mem_to_reg),
        .reg_dst       (reg_dst),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .ext_sel       (ext_sel),
        .illegal_op    (illegal_op),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .pc_source     (pc_source),
        .state         (state)
    );

    logic [17:0] dut_vec;
    assign dut_vec = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                      mem_to_reg, reg_dst, reg_write, alu_src_a, ext_sel, illegal_op,
                      alu_src_b, alu_op, pc_source};

    logic [5:0] legal_tab [8] = '{6'h00, 6'h02, 6'h04, 6'h08, 6'h0C, 6'h0D, 6'h23, 6'h2B};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit legal(input logic [5:0] op);
        return op inside {6'h00, 6'h02, 6'h04, 6'h08, 6'h0C, 6'h0D, 6'h23, 6'h2B};
    endfunction

    // Expected strobes for one cycle, straight from the per-state output table.
    function automatic logic [17:0] exp_vec(input int st, input logic [5:0] opq,
                                            input logic [5:0] op, input logic rdy);
        logic pw, pwc, iod, mr, mw, irw, m2r, rd, rw, asa, ext, ill, logi;
        logic [1:0] sb, ao, ps;
        {pw, pwc, iod, mr, mw, irw, m2r, rd, rw, asa, ext, ill} = '0;
        sb = 2'b00; ao = 2'b00; ps = 2'b00;
        logi = (opq == 6'h0C) || (opq == 6'h0D);
        case (st)
            1:  begin mr = 1; sb = 2'b01; irw = rdy; pw = rdy; end
            2:  begin sb = 2'b11; ill = !legal(op); end
            3:  begin asa = 1; sb = 2'b10; end
            4:  begin iod = 1; mr = 1; end
            5:  begin rw = 1; m2r = 1; end
            6:  begin iod = 1; mw = 1; end
            7:  begin asa = 1; ao = 2'b10; end
            8:  begin rw = 1; rd = 1; end
            9:  begin asa = 1; ao = 2'b01; pwc = 1; ps = 2'b01; end
            10: begin pw = 1; ps = 2'b10; end
            11, 12: begin
                asa = 1; sb = 2'b10; ao = logi ? 2'b11 : 2'b00; ext = logi; rw = (st == 12);
            end
            default: ;
        endcase
        return {pw, pwc, iod, mr, mw, irw, m2r, rd, rw, asa, ext, ill, sb, ao, ps};
    endfunction

    // Reference model: an instruction is a list of states visited after DECODE;
    // memory states wait for mem_ready, an empty list means back to FETCH.
    int         m_state = 0;
    int         m_rel = 0;
    logic [5:0] m_op = 6'h00;
    int         m_seq [$];

    task automatic load_seq(input logic [5:0] op);
        m_seq.delete();
        case (op)
            6'h23: begin m_seq.push_back(3); m_seq.push_back(4); m_seq.push_back(5); end
            6'h2B: begin m_seq.push_back(3); m_seq.push_back(6); end
            6'h00: begin m_seq.push_back(7); m_seq.push_back(8); end
            6'h04: m_seq.push_back(9);
            6'h02: m_seq.push_back(10);
            6'h08, 6'h0C, 6'h0D: begin m_seq.push_back(11); m_seq.push_back(12); end
            default: ;
        endcase
    endtask

    task automatic adv();
        if (m_seq.size() != 0) m_state = m_seq.pop_front();
        else m_state = 1;
    endtask

    task automatic model_reset();
        m_state = 0; m_rel = 0; m_op = 6'h00; m_seq.delete();
    endtask

    always begin
        @(negedge clk);
        #4;
        if (!rst_n) model_reset();
        chk("model_state", state, m_state);
        chk("model_outputs", dut_vec, exp_vec(m_state, m_op, opcode, mem_ready));
        chk("rd_wr_exclusive", mem_read & mem_write, 0);
        @(posedge clk);
        if (!rst_n) model_reset();
        else begin
            case (m_state)
                0: begin m_rel++; if (m_rel >= 2) m_state = 1; end
                1: if (mem_ready) m_state = 2;
                2: begin m_op = opcode; load_seq(opcode); adv(); end
                4, 6: if (mem_ready) adv();
                default: adv();
            endcase
        end
    end

    // One cycle: drive at the falling edge, return just before the next rising edge.
    task automatic cyc(input logic r, input logic [5:0] op, input logic rdy);
        @(negedge clk);
        rst_n = r; opcode = op; mem_ready = rdy;
        #4;
    endtask

    task automatic do_reset();
        cyc(0, 6'h00, 0); chk("rst_state", state, 0); chk("rst_outputs", dut_vec, 0);
        cyc(0, 6'h3F, 1); chk("rst_hold_outputs", dut_vec, 0);
        cyc(1, 6'h00, 1); chk("release_edge0", state, 0);
        cyc(1, 6'h00, 1); chk("release_edge1", state, 0);
    endtask

    initial begin
        // R-type: 0,1,2,7,8,1 with register write only in ALU_WB
        do_reset();
        cyc(1, 6'h00, 1); chk("r_fetch", state, 1); chk("r_ir_write", ir_write, 1);
        cyc(1, 6'h00, 1); chk("r_decode", state, 2);
        cyc(1, 6'h00, 1); chk("r_execute", state, 7); chk("r_exec_no_wr", reg_write, 0);
        cyc(1, 6'h00, 1); chk("r_alu_wb", state, 8); chk("r_wb_strobes", {reg_write, reg_dst}, 2'b11);
        cyc(1, 6'h00, 1); chk("r_back_fetch", state, 1);

        // LW with three wait cycles in MEM_READ
        do_reset();
        cyc(1, 6'h23, 1); chk("lw_fetch", state, 1);
        cyc(1, 6'h23, 1); chk("lw_decode", state, 2);
        cyc(1, 6'h23, 0); chk("lw_mem_addr", state, 3);
        for (int i = 0; i < 4; i++) begin
            cyc(1, 6'h23, (i == 3));
            chk("lw_mem_read", state, 4); chk("lw_read_strobes", {mem_read, i_or_d}, 2'b11);
        end
        cyc(1, 6'h00, 1); chk("lw_mem_wb", state, 5); chk("lw_wb_strobes", {reg_write, mem_to_reg}, 2'b11);
        cyc(1, 6'h00, 1); chk("lw_back_fetch", state, 1);

        // Immediates: ORI zero-extends with logic op, ADDI sign-extends with add
        cyc(1, 6'h0D, 1); chk("ori_decode", state, 2);
        cyc(1, 6'h0D, 1); chk("ori_exec", state, 11); chk("ori_ctrl", {ext_sel, alu_op}, 3'b111);
        cyc(1, 6'h0D, 1); chk("ori_wb", state, 12); chk("ori_wb_wr", reg_write, 1);
        cyc(1, 6'h08, 1); chk("addi_fetch", state, 1);
        cyc(1, 6'h08, 1); chk("addi_decode", state, 2);
        cyc(1, 6'h08, 1); chk("addi_exec", state, 11); chk("addi_ctrl", {ext_sel, alu_op}, 3'b000);
        cyc(1, 6'h08, 1); chk("addi_wb", state, 12);
        cyc(1, 6'h00, 1); chk("addi_back_fetch", state, 1);

        // Illegal opcode
        cyc(1, 6'h3F, 1); chk("ill_decode", state, 2); chk("ill_pulse", illegal_op, 1);
        chk("ill_no_write", {reg_write, mem_write}, 2'b00);
        cyc(1, 6'h00, 1); chk("ill_fetch", state, 1); chk("ill_cleared", illegal_op, 0);

        // Reset during a MEM_WRITE wait
        cyc(1, 6'h2B, 1); chk("sw_decode", state, 2);
        cyc(1, 6'h2B, 0); chk("sw_mem_addr", state, 3);
        cyc(1, 6'h2B, 0); chk("sw_mem_write", state, 6); chk("sw_strobe", mem_write, 1);
        @(negedge clk);
        #1; chk("sw_wait_strobe", mem_write, 1);
        rst_n = 1'b0;
        #1; chk("sw_abort_strobe", mem_write, 0); chk("sw_abort_state", state, 0);
        #2;
        cyc(0, 6'h00, 1); chk("sw_rst_held", state, 0);
        cyc(1, 6'h00, 1); chk("sw_rel0", state, 0);
        cyc(1, 6'h00, 1); chk("sw_rel1", state, 0);
        cyc(1, 6'h00, 1); chk("sw_rel_fetch", state, 1);

        // Opcode changes after DECODE: latched LW still reads
        do_reset();
        cyc(1, 6'h23, 1); chk("opq_fetch", state, 1);
        cyc(1, 6'h23, 1); chk("opq_decode", state, 2);
        cyc(1, 6'h2B, 1); chk("opq_mem_addr", state, 3);
        cyc(1, 6'h2B, 1); chk("opq_mem_read", state, 4); chk("opq_read_strobes", {mem_read, mem_write}, 2'b10);

        // Randomized traffic with occasional mid-cycle resets
        begin
            int rst_left;
            rst_left = 0;
            for (int i = 0; i < 3000; i++) begin
                logic [5:0] op;
                logic       rdy;
                op  = ($urandom_range(0, 3) != 0) ? legal_tab[$urandom_range(0, 7)] : 6'($urandom());
                rdy = ($urandom_range(0, 3) != 0);
                if (rst_left > 0) begin
                    cyc(0, op, rdy);
                    rst_left--;
                end else if ($urandom_range(0, 149) == 0) begin
                    @(negedge clk);
                    opcode = op; mem_ready = rdy;
                    #2 rst_n = 1'b0;
                    #2;
                    rst_left = $urandom_range(0, 2);
                end else begin
                    cyc(1, op, rdy);
                end
            end
        end

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
